// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART-fed instruction RAM loader with length header, XOR check and timeout
module imem_uart_loader #(
    parameter int MEM_WORDS = 160,
    parameter int TIMEOUT   = 1000000,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_en,
    output logic [30:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       err_nxt;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] len;
    logic [7:0]       len_hi;
    logic [7:0]       csum;
    logic [23:0]      shift;
    logic [TO_W-1:0]  to_cnt;

    logic             loading;
    logic             go;
    logic             timed_out;
    logic [CNT_W-1:0] len_val;
    logic             len_bad;
    logic             word_done;
    logic             last_word;

    assign loading   = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign go        = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign timed_out = loading && !rx_valid && (to_cnt == TO_W'(TIMEOUT - 1));
    assign len_val   = CNT_W'({len_hi, rx_data});
    assign len_bad   = (len_val == '0) || (len_val > CNT_W'(MEM_WORDS));
    assign word_done = (state == S_DATA) && rx_valid && (byte_cnt == 2'd3);
    assign last_word = (word_cnt == len - CNT_W'(1));

    assign busy     = loading;
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);
    assign cpu_hold = loading || (state == S_ERR);

    // State and error-cause registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            err_code <= 2'd0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
        end
    end

    // Next-state and error-cause selection; timeout overrides byte handling
    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    state_nxt = S_LEN;
                    err_nxt   = 2'd0;
                end
            end
            S_LEN: begin
                if (timed_out) begin
                    state_nxt = S_ERR;
                    err_nxt   = 2'd2;
                end else if (rx_valid && byte_cnt[0]) begin
                    if (len_bad) begin
                        state_nxt = S_ERR;
                        err_nxt   = 2'd1;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (timed_out) begin
                    state_nxt = S_ERR;
                    err_nxt   = 2'd2;
                end else if (word_done && last_word) begin
                    state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (timed_out) begin
                    state_nxt = S_ERR;
                    err_nxt   = 2'd2;
                end else if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                        err_nxt   = 2'd3;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                err_nxt   = 2'd0;
            end
        endcase
    end

    // Byte assembly, counters, checksum, idle timer and the write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            len      <= '0;
            len_hi   <= 8'd0;
            csum     <= 8'd0;
            shift    <= 24'd0;
            to_cnt   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= 31'd0;
            wr_data  <= 32'd0;
        end else begin
            wr_en <= word_done;
            if (word_done) begin
                wr_addr <= {{(31 - CNT_W - 2){1'b0}}, word_cnt, 2'b00};
                wr_data <= {shift, rx_data};
            end
            if (go) begin
                byte_cnt <= 2'd0;
                word_cnt <= '0;
                len_hi   <= 8'd0;
                csum     <= 8'd0;
                to_cnt   <= '0;
            end else if (loading) begin
                to_cnt <= rx_valid ? '0 : to_cnt + TO_W'(1);
                if (rx_valid) begin
                    if (state == S_LEN) begin
                        if (!byte_cnt[0]) begin
                            len_hi   <= rx_data;
                            byte_cnt <= 2'd1;
                        end else begin
                            len      <= len_val;
                            byte_cnt <= 2'd0;
                        end
                    end else if (state == S_DATA) begin
                        shift    <= {shift[15:0], rx_data};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer-side counterpart of the instruction memory: receives a program image byte-by-byte from the UART receiver and writes 32-bit instruction words into the instruction RAM at word-aligned byte addresses.
- Sits between the UART RX byte interface and the instruction RAM write port.
- Holds the CPU in reset while loading, then releases it once the image is checksum-verified.

Parameters:
- MEM_WORDS, 160, instruction memory depth in words; the maximum image length.
- TIMEOUT, 1000000, maximum idle clock cycles between received bytes during a load.
- CNT_W, 16, width of the word-count header and the word counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; ignored unless the FSM is in IDLE, DONE or ERR.
- rx_valid  input  1  single-cycle strobe: rx_data holds a new byte.
- rx_data  input  8  received byte.
- wr_en  output  1  instruction RAM write strobe, one cycle per word.
- wr_addr  output  31  byte address of the write; always word-aligned (bits [1:0]=0), same addressing as the fetch port.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  high while loading; used as the CPU reset.
- busy  output  1  high in LEN, DATA and CHK.
- done  output  1  high in DONE (load verified).
- error  output  1  high in ERR.
- err_code  output  2  error cause: 0 none, 1 bad length, 2 timeout, 3 checksum.

Behaviour:
- Reset (asynchronous): state IDLE, all counters 0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, error=0, err_code=0.
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE/DONE/ERR → LEN on start:
  - clear the byte counter, word counter, checksum and timeout counter;
  - clear done, error and err_code;
  - assert cpu_hold in the next cycle.
- LEN: accepts 2 bytes, big-endian, forming N.
  - After the 2nd byte: if N==0 or N>MEM_WORDS → ERR with err_code=1; otherwise → DATA.
- DATA: accepts 4N bytes, big-endian per word (the first byte lands in bits [31:24]).
  - Every data byte is XORed into an 8-bit checksum.
  - On the 4th byte of word i: in the next cycle, wr_en=1 for exactly one cycle with wr_addr={i,2'b00} and wr_data equal to the assembled word.
  - After word N-1 is written → CHK.
- CHK: accepts 1 byte.
  - If it equals the running XOR → DONE; otherwise → ERR with err_code=3.
  - The check byte is not written to memory.
- DONE: cpu_hold=0, done=1. Memory contents are retained.
- ERR: cpu_hold stays 1, so the CPU does not run a partial image. error=1, err_code holds its value until the next start or reset.
- Timeout: in LEN, DATA and CHK, a counter increments each cycle without rx_valid and resets on rx_valid. When it reaches TIMEOUT → ERR with err_code=2.
- rx_valid in IDLE, DONE or ERR is ignored.
- start while busy is ignored. A load in progress cannot be restarted except by reset.
- start and rx_valid in the same cycle in IDLE: start wins and the byte is discarded.
- Reset mid-load: everything returns to reset values. A write pulse already in flight is cancelled. cpu_hold drops.
- wr_addr and wr_data hold their last written values between strobes.
- Word counter width is CNT_W; the comparison with MEM_WORDS is unsigned.

Test Plan:
- Normal load: start; send 00 02, 3C 10 40 00, 08 00 00 03, then check byte 0x3C^0x10^0x40^0x00^0x08^0x00^0x00^0x03=0x67 → exactly two writes: (addr 0x0, 0x3C104000) and (addr 0x4, 0x08000003); done=1; cpu_hold=0; err_code=0.
- Bad length: send 00 00 → error=1, err_code=1, wr_en never asserted. Repeat with 00 A1 (161) → same result.
- Checksum mismatch: the normal stream with check byte 0x68 → both writes occur; error=1; err_code=3; cpu_hold=1.
- Timeout: with TIMEOUT=50, stop after 5 data bytes → ERR with err_code=2 at the 50th idle cycle; only 1 write performed.
- Mid-load reset: assert reset_n low after the 3rd data byte, then restart a full load → all outputs at reset values while low; the subsequent load completes with correct writes starting from addr 0.
- Ignored inputs: rx_valid pulses in IDLE, and start pulses during DATA → no state change, no writes; the load completes normally.
